// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the compression-SRAM arbiter.
//   arb_state_t  : arbiter FSM states
//   REQ_*        : requester indices (0 = host init port, highest fixed priority)
//   NREQ/ADDR_W/DATA_W/IDX_W : bus geometry shared by the interface, arbiter and picker
//   idx_onehot() : index to one-hot requester vector
package mem_arb_pkg;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = $clog2(NREQ);

  localparam int unsigned REQ_HOST = 0;
  localparam int unsigned REQ_BT   = 1;
  localparam int unsigned REQ_CT   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  function automatic logic [NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/SRAM bus of the compression-SRAM arbiter.
//   Requester side : req, req_wr, req_addr, req_wdata (packed, requester i at slice i)
//                    gnt, rvalid, rdata, busy
//   SRAM side      : mem_addr, mem_data_W, mem_R, mem_W, mem_data_R
// Modports: slave = the arbiter, master = requesters plus SRAM (the environment).
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_data_W;
  logic                   mem_R;
  logic                   mem_W;
  logic [DATA_W-1:0]      mem_data_R;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, mem_data_R,
    output gnt, rvalid, rdata, busy, mem_addr, mem_data_W, mem_R, mem_W
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, mem_data_R,
    input  gnt, rvalid, rdata, busy, mem_addr, mem_data_W, mem_R, mem_W
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner select for the SRAM arbiter.
//   req_i   : request vector
//   ptr_i   : round-robin search start (ignored in fixed-priority builds)
//   idx_o   : winning requester index
//   found_o : at least one request is asserted
// Build option: MEM_ARB_RR_EN selects round-robin search from ptr_i; otherwise the
// lowest asserted index wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    logic [IDX_W-1:0] cand;
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    // Walk NREQ slots starting at ptr_i, wrapping past NREQ-1 back to 0.
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % NREQ);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Descending scan so the lowest asserted index is the last (winning) assignment.
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port compression SRAM between host init port (0),
// build_tree (1) and code_table (2). One access at a time: IDLE -> ISSUE -> (WAIT -> DONE).
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (requester handshake plus SRAM strobes/address/data)
// Parameter RD_LAT: SRAM read latency in cycles (>= 1); mem_R is held for the whole latency.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration with a pointer register;
// undefined gives fixed priority (lowest index wins) with no pointer.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input logic           clk,
  input logic           n_rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [IDX_W-1:0]  ptr;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  arb_pick u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef MEM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          wr_d    = bus.req_wr[pick_idx];
          addr_d  = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef MEM_ARB_RR_EN
        ptr_d = (32'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
`endif
        if (wr_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bus.mem_data_R;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Outputs decode from state and latched registers only; address and write data stay
  // on the latched values so they are stable through the whole read window.
  assign bus.gnt        = (state_q == ISSUE) ? idx_onehot(idx_q) : '0;
  assign bus.rvalid     = (state_q == DONE) ? idx_onehot(idx_q) : '0;
  assign bus.mem_W      = (state_q == ISSUE) && wr_q;
  assign bus.mem_R      = ((state_q == ISSUE) && !wr_q) || (state_q == WAIT);
  assign bus.busy       = (state_q != IDLE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_data_W = wdata_q;
  assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned RdLat = 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   viol = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .RD_LAT (RdLat)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: writes on the strobe, reads through a RdLat-deep pipeline.
  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe;
  always @(posedge clk) begin
    if (bus.mem_W) sram[bus.mem_addr] <= bus.mem_data_W;
    rd_pipe        <= sram[bus.mem_addr];
    bus.mem_data_R <= rd_pipe;
  end

  // Bus invariants, accumulated every cycle and checked once at the end.
  always @(negedge clk) begin
    if (n_rst) begin
      if (!$onehot0(bus.gnt) || !$onehot0(bus.rvalid) || (bus.mem_R && bus.mem_W) ||
          ((|bus.gnt || |bus.rvalid || bus.mem_R || bus.mem_W) && !bus.busy))
        viol <= viol + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic apply_reset();
    bus.req = '0;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic do_write(input int r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          output int glat, output int w_in, output int a_in, output int w_after);
    bus.req_wr[r] = 1'b1;
    bus.req_addr[r*ADDR_W +: ADDR_W] = a;
    bus.req_wdata[r*DATA_W +: DATA_W] = wd;
    bus.req[r] = 1'b1;
    glat = -1; w_in = -1; a_in = -1; w_after = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.gnt[r]) begin
        glat = c; w_in = int'(bus.mem_W); a_in = int'(bus.mem_addr);
        break;
      end
    end
    bus.req[r] = 1'b0;
    @(posedge clk); #1;
    w_after = int'(bus.mem_W);
  endtask

  task automatic do_read(input int r, input logic [ADDR_W-1:0] a,
                         output int glat, output int vlat, output int d);
    bus.req_wr[r] = 1'b0;
    bus.req_addr[r*ADDR_W +: ADDR_W] = a;
    bus.req[r] = 1'b1;
    glat = -1; vlat = -1; d = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.gnt[r] && glat < 0) begin
        glat = c;
        bus.req[r] = 1'b0;
      end
      if (bus.rvalid[r]) begin
        vlat = c; d = int'(bus.rdata);
        break;
      end
    end
    bus.req[r] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int gl, vl, dd, wi, ai, wa;
    int gord[$];
    int rord[$];
    int rdat[$];
    int rises, v1, g1, g2, rv_cnt, busy_cnt;
    logic prev_r;
    int exp_rd[3];
    int exp_g4[6];

    bus.req = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;
    apply_reset();

    // Reset state
    check("rst_busy", int'(bus.busy), 0);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_rvalid", int'(bus.rvalid), 0);
    check("rst_mem_rw", int'({bus.mem_R, bus.mem_W}), 0);
    check("rst_rdata", int'(bus.rdata), 0);
    check("rst_addr", int'(bus.mem_addr), 0);

    // Host write then BT read of the same location
    do_write(REQ_HOST, 10'h080, 8'h05, gl, wi, ai, wa);
    check("t2_w_gnt_lat", gl, 1);
    check("t2_w_memW", wi, 1);
    check("t2_w_addr", ai, 'h080);
    check("t2_w_memW_after", wa, 0);
    do_read(REQ_BT, 10'h080, gl, vl, dd);
    check("t2_r_gnt_lat", gl, 1);
    check("t2_r_rvalid_lat", vl, RdLat + 2);
    check("t2_r_data", dd, 'h05);

    // Back-to-back BT write then read
    do_write(REQ_BT, 10'h101, 8'h03, gl, wi, ai, wa);
    check("t6_w_gnt_lat", gl, 1);
    check("t6_w_memW", wi, 1);
    do_read(REQ_BT, 10'h101, gl, vl, dd);
    check("t6_r_gnt_lat", gl, 1);
    check("t6_r_rvalid_lat", vl, RdLat + 2);
    check("t6_r_data", dd, 'h03);

    // Reset in the second WAIT cycle of a CT read
    bus.req_wr[REQ_CT] = 1'b0;
    bus.req_addr[REQ_CT*ADDR_W +: ADDR_W] = 10'h180;
    bus.req[REQ_CT] = 1'b1;
    gl = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.gnt[REQ_CT]) begin gl = c; break; end
    end
    bus.req[REQ_CT] = 1'b0;
    check("t1_gnt_lat", gl, 1);
    repeat (2) @(posedge clk);
    #1;
    check("t1_in_wait", int'({bus.busy, bus.mem_R}), 3);
    #1 n_rst = 1'b0;
    #1;
    check("t1_gnt", int'(bus.gnt), 0);
    check("t1_rvalid", int'(bus.rvalid), 0);
    check("t1_mem_rw", int'({bus.mem_R, bus.mem_W}), 0);
    check("t1_busy", int'(bus.busy), 0);
    check("t1_rdata", int'(bus.rdata), 0);
    check("t1_addr", int'(bus.mem_addr), 0);
    check("t1_wdata", int'(bus.mem_data_W), 0);
    @(posedge clk); #1 n_rst = 1'b1;
    rv_cnt = 0; busy_cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (|bus.rvalid) rv_cnt++;
      if (bus.busy) busy_cnt++;
    end
    check("t1_no_rvalid", rv_cnt, 0);
    check("t1_idle", busy_cnt, 0);

    // Three simultaneous reads
    do_write(REQ_HOST, 10'h081, 8'h02, gl, wi, ai, wa);
    do_write(REQ_HOST, 10'h082, 8'h01, gl, wi, ai, wa);
    do_write(REQ_HOST, 10'h083, 8'h04, gl, wi, ai, wa);
    apply_reset();
    bus.req_wr = '0;
    bus.req_addr = {10'h083, 10'h082, 10'h081};
    bus.req = 3'b111;
    rises = 0; prev_r = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (bus.gnt[i]) begin gord.push_back(i); bus.req[i] = 1'b0; end
        if (bus.rvalid[i]) begin rord.push_back(i); rdat.push_back(int'(bus.rdata)); end
      end
      if (bus.mem_R && !prev_r) rises++;
      prev_r = bus.mem_R;
      if (rord.size() == 3) break;
    end
    bus.req = '0;
    @(posedge clk); #1;
    exp_rd = '{2, 1, 4};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_gnt%0d", i), (gord.size() > i) ? gord[i] : -1, i);
      check($sformatf("t3_rv%0d", i), (rord.size() > i) ? rord[i] : -1, i);
      check($sformatf("t3_data%0d", i), (rdat.size() > i) ? rdat[i] : -1, exp_rd[i]);
    end
    check("t3_memR_windows", rises, 3);

    // Continuous requests from everyone
    apply_reset();
    gord.delete();
    bus.req_wr = '0;
    bus.req = 3'b111;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (bus.gnt[i]) gord.push_back(i);
      if (gord.size() == 6) break;
    end
    bus.req = '0;
    repeat (6) @(posedge clk);
    #1;
`ifdef MEM_ARB_RR_EN
    exp_g4 = '{0, 1, 2, 0, 1, 2};
`else
    exp_g4 = '{0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 6; i++)
      check($sformatf("t4_gnt%0d", i), (gord.size() > i) ? gord[i] : -1, exp_g4[i]);
    check("t4_idle", int'(bus.busy), 0);

    // BT drops req in its ISSUE cycle, CT write pending behind it
    apply_reset();
    bus.req_wr = 3'b100;
    bus.req_addr = {10'h100, 10'h080, 10'h000};
    bus.req_wdata = {8'hFF, 8'h00, 8'h00};
    bus.req = 3'b110;
    g1 = -1; v1 = -1; g2 = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.gnt[REQ_BT]) begin g1 = c; bus.req[REQ_BT] = 1'b0; end
      if (bus.rvalid[REQ_BT]) begin v1 = c; dd = int'(bus.rdata); end
      if (bus.gnt[REQ_CT]) begin g2 = c; bus.req[REQ_CT] = 1'b0; break; end
    end
    bus.req = '0;
    @(posedge clk); #1;
    check("t5_bt_gnt", g1, 1);
    check("t5_bt_rvalid", v1, RdLat + 2);
    check("t5_bt_data", dd, 'h05);
    check("t5_ct_gnt", g2, RdLat + 4);
    do_read(REQ_HOST, 10'h100, gl, vl, dd);
    check("t5_ct_written", dd, 'hFF);

    @(negedge clk);
    check("invariants", viol, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
